uart_tx_feeder: RTL and testbench

//  Byte-stream front end placed directly upstream of the MiniUART transmit path.
//  It buffers bytes pushed by a producer, such as the CPU bridge or a debug block, in a FIFO.
//  It then drains the FIFO into the UART through a WISHBONE master port.

---
 rtl/uart_tx_feeder_if.sv | 26 ++
 rtl/uart_tx_feeder.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : uart_tx_feeder_if
// Brief   : WISHBONE master/slave bundle between the feeder and the MiniUART.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_feeder_if;
    logic [2:0]  ADD_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I;

    modport master (
        output ADD_O, DAT_O, STB_O, WE_O,
        input  DAT_I, ACK_I
    );

    modport slave (
        input  ADD_O, DAT_O, STB_O, WE_O,
        output DAT_I, ACK_I
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : uart_tx_feeder
// Brief   : Byte FIFO drained into the MiniUART DATA register after LSR polling.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int         DEPTH     = 16,
    parameter int         AW        = 4,
    parameter logic [2:0] ADDR_DATA = 3'd0,
    parameter logic [2:0] ADDR_LSR  = 3'd1,
    parameter int         TS_BIT    = 5,
    parameter int         GUARD_CYC = 3
) (
    input  wire logic          CLK_I,
    input  wire logic          RST_I,
    input  wire logic          push_valid,
    input  wire logic [7:0]    push_data,
    output      logic          push_ready,
    input  wire logic          flush,
    output      logic [AW:0]   fifo_count,
    output      logic          busy,
    uart_tx_feeder_if.master   wb
);

    localparam int          GW         = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POLL  = 2'd1,
        S_WRITE = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic            flush_pend_q, flush_pend_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [2:0]      add_q, add_d;
    logic [31:0]     dat_q, dat_d;
    logic [7:0]      mem_q [DEPTH];

    logic            do_push;
    logic            do_pop;
    logic            unused_dat;

    assign unused_dat = ^wb.DAT_I;

    assign push_ready = RST_I & (count_q != FULL_COUNT);
    assign do_push    = push_valid & push_ready & ~flush;
    // A write acked after a flush retires on the bus but must not pop the cleared FIFO.
    assign do_pop     = (state_q == S_WRITE) & wb.ACK_I & ~flush & ~flush_pend_q;

    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) | (count_q != '0);

    assign wb.STB_O = stb_q;
    assign wb.WE_O  = we_q;
    assign wb.ADD_O = add_q;
    assign wb.DAT_O = dat_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        guard_d      = guard_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            S_IDLE: begin
                if (!flush && count_q != '0) state_d = S_POLL;
            end
            S_POLL: begin
                if (flush)                                state_d = S_IDLE;
                else if (wb.ACK_I && wb.DAT_I[TS_BIT])    state_d = S_WRITE;
            end
            S_WRITE: begin
                if (flush) flush_pend_d = 1'b1;
                if (wb.ACK_I) begin
                    if (flush || flush_pend_q) begin
                        state_d      = S_IDLE;
                        flush_pend_d = 1'b0;
                    end else begin
                        guard_d = GUARD_LOAD;
                        state_d = S_GUARD;
                    end
                end
            end
            S_GUARD: begin
                if (flush)                state_d = S_IDLE;
                else if (guard_q == '0)   state_d = (count_q != '0) ? S_POLL : S_IDLE;
                else                      guard_d = guard_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they change only on edges.
    always_comb begin
        stb_d = 1'b0;
        we_d  = 1'b0;
        add_d = 3'd0;
        dat_d = 32'd0;
        case (state_d)
            S_POLL: begin
                stb_d = 1'b1;
                add_d = ADDR_LSR;
            end
            S_WRITE: begin
                stb_d = 1'b1;
                we_d  = 1'b1;
                add_d = ADDR_DATA;
                dat_d = (state_q == S_WRITE) ? dat_q : {24'd0, mem_q[rd_ptr_q]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            guard_q      <= '0;
            flush_pend_q <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            add_q        <= 3'd0;
            dat_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            guard_q      <= guard_d;
            flush_pend_q <= flush_pend_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            add_q        <= add_d;
            dat_q        <= dat_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_uart_tx_feeder
// Brief   : Directed and randomized bench with a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int TS_BIT = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push_valid;
    logic [7:0]    push_data;
    logic          push_ready;
    logic          flush;
    logic [AW:0]   fifo_count;
    logic          busy;
    logic          ts;

    always #5 clk = ~clk;

    uart_tx_feeder_if bus();

    // UART model: combinational ACK, LSR returns the transmitter-ready flag.
    assign bus.ACK_I = bus.STB_O;
    assign bus.DAT_I = (bus.STB_O && !bus.WE_O && bus.ADD_O == 3'd1) ? (32'(ts) << TS_BIT) : 32'h0;

    uart_tx_feeder dut (
        .CLK_I      (clk),
        .RST_I      (rst_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .flush      (flush),
        .fifo_count (fifo_count),
        .busy       (busy),
        .wb         (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_polls = 0;
    int         n_writes = 0;
    int         n_badbus = 0;
    logic [7:0] wr_log [$];
    logic [7:0] exp_q  [$];

    always @(posedge clk) begin
        if (rst_n && bus.STB_O && bus.ACK_I) begin
            if (bus.WE_O) begin
                wr_log.push_back(bus.DAT_O[7:0]);
                n_writes++;
                if (bus.ADD_O !== 3'd0 || bus.DAT_O[31:8] !== 24'd0) n_badbus++;
            end else begin
                n_polls++;
                if (bus.ADD_O !== 3'd1) n_badbus++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d);
        push_valid = 1'b1;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int c = 0;
        while (busy && c < bound) begin
            tick();
            c++;
        end
        chk("drain_done", 32'(busy), 0);
    endtask

    task automatic wait_write(input int bound);
        int c = 0;
        while (!(bus.STB_O && bus.WE_O) && c < bound) begin
            tick();
            c++;
        end
        chk("write_seen", 32'(bus.STB_O && bus.WE_O), 1);
    endtask

    task automatic check_log(input int base);
        int n = wr_log.size() - base;
        chk("log_len", n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            chk("log_byte", wr_log[base+i], exp_q[i]);
    endtask

    initial begin
        int         lb;
        int         pb;
        int         wb0;
        int         occ;
        logic       acc;
        logic [7:0] d;

        rst_n = 1'b0; push_valid = 1'b0; push_data = 8'h00; flush = 1'b0; ts = 1'b1;
        tick(3);
        chk("rst_stb", 32'(bus.STB_O), 0);
        chk("rst_we", 32'(bus.WE_O), 0);
        chk("rst_add", 32'(bus.ADD_O), 0);
        chk("rst_dat", bus.DAT_O, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready_low", 32'(push_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(push_ready), 1);
        tick();

        // Single byte latency
        exp_q.delete(); lb = wr_log.size();
        push_one(8'h41); exp_q.push_back(8'h41);
        chk("t2_count", fifo_count, 1);
        chk("t2_idle_stb", 32'(bus.STB_O), 0);
        tick();
        chk("t2_poll", {bus.STB_O, bus.WE_O, bus.ADD_O}, 5'b10_001);
        tick();
        chk("t2_write", {bus.STB_O, bus.WE_O, bus.ADD_O}, 5'b11_000);
        chk("t2_dat", bus.DAT_O, 32'h41);
        tick();
        chk("t2_guard_stb", 32'(bus.STB_O), 0);
        chk("t2_popped", fifo_count, 0);
        chk("t2_guard_busy", 32'(busy), 1);
        tick(3);
        chk("t2_idle_busy", 32'(busy), 0);
        check_log(lb);

        // Backpressure
        ts = 1'b0; exp_q.delete(); lb = wr_log.size(); wb0 = n_writes;
        push_one(8'h5A); exp_q.push_back(8'h5A);
        pb = n_polls;
        tick(21);
        chk("t3_polls", n_polls - pb, 20);
        chk("t3_no_write", n_writes - wb0, 0);
        ts = 1'b1;
        drain(50);
        chk("t3_one_write", n_writes - wb0, 1);
        check_log(lb);

        // Full FIFO
        ts = 1'b0; exp_q.delete(); lb = wr_log.size();
        for (int i = 0; i < DEPTH; i++) begin
            push_one(8'(i)); exp_q.push_back(8'(i));
        end
        chk("t4_full_count", fifo_count, DEPTH);
        chk("t4_not_ready", 32'(push_ready), 0);
        push_one(8'hFF);
        chk("t4_push_ignored", fifo_count, DEPTH);
        ts = 1'b1;
        drain(400);
        check_log(lb);

        // Randomized traffic against the queue model
        exp_q.delete(); lb = wr_log.size();
        for (int i = 0; i < 300; i++) begin
            occ = exp_q.size() - (wr_log.size() - lb);
            chk("rnd_count", fifo_count, occ);
            chk("rnd_ready", 32'(push_ready), 32'(occ < DEPTH));
            d          = 8'($urandom);
            push_valid = 1'($urandom_range(0, 1));
            push_data  = d;
            ts         = ($urandom_range(0, 3) != 0);
            acc        = push_valid && (occ < DEPTH);
            tick();
            if (acc) exp_q.push_back(d);
        end
        push_valid = 1'b0; ts = 1'b1;
        drain(400);
        check_log(lb);

        // Push coinciding with a WRITE ack
        ts = 1'b0; exp_q.delete(); lb = wr_log.size();
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom); push_one(d); exp_q.push_back(d);
        end
        chk("t5_count5", fifo_count, 5);
        ts = 1'b1;
        wait_write(20);
        d = 8'($urandom);
        push_one(d); exp_q.push_back(d);
        chk("t5_count_held", fifo_count, 5);
        drain(200);
        check_log(lb);

        // Flush while polling
        ts = 1'b0; wb0 = n_writes;
        push_one(8'h11); push_one(8'h22); push_one(8'h33);
        tick();
        chk("t6_polling", {bus.STB_O, bus.WE_O}, 2'b10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_count", fifo_count, 0);
        chk("t6_stb", 32'(bus.STB_O), 0);
        chk("t6_busy", 32'(busy), 0);
        ts = 1'b1;
        tick(10);
        chk("t6_no_write", n_writes - wb0, 0);

        // Reset during a DATA write
        ts = 1'b1;
        push_one(8'h55);
        wait_write(20);
        rst_n = 1'b0;
        #1;
        chk("t1_stb_drop", 32'(bus.STB_O), 0);
        chk("t1_count", fifo_count, 0);
        wb0 = n_writes;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("t1_no_write", n_writes - wb0, 0);
        chk("t1_quiet", 32'(bus.STB_O), 0);
        chk("t1_busy", 32'(busy), 0);

        chk("bus_fields", n_badbus, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
